hs_rx_deserializer: RTL and testbench
=====================================

HS_RX_DESERIALIZER -- requirements
Module: hs_rx_deserializer

Interface
REQ-001 The block SHALL provide parameter SYNC_WORD, default 8'hB8, as the HS leader/sync byte, LSB-first on the wire.
REQ-002 The block SHALL provide parameter HUNT_TIMEOUT, default 64, as the maximum hunt duration in clock cycles; legal range 4..1023.
REQ-003 RX_DDR_clk  input  1  Single receive clock; all logic on its rising edge.
REQ-004 RX_rst  input  1  Reset, synchronous, active-high.
REQ-005 Enable  input  1  HS receive enable from the lane LP/HS detector.
REQ-006 Serial_B1  input  1  Earlier wire bit of the current pair (rising-edge sample).
REQ-007 Serial_B2  input  1  Later wire bit of the current pair (falling-edge sample).
REQ-008 Byte_out  output  8  Recovered payload byte, LSB = first received bit.
REQ-009 Byte_valid  output  1  One-cycle strobe qualifying Byte_out.
REQ-010 Sync_found  output  1  One-cycle strobe on sync-word detection.
REQ-011 Active  output  1  High while in RECEIVE.
REQ-012 Sync_err  output  1  One-cycle strobe on hunt timeout; tied 0 when REQ-028 is disabled.

Function
REQ-013 The block SHALL consume exactly 2 bits per cycle while Enable=1, with B1 ordered before B2.
REQ-014 The block SHALL keep a 16-bit history shreg and update it each enabled cycle as shreg <= {B2, B1, shreg[15:2]}.
REQ-015 The FSM SHALL have the states IDLE, HUNT and RECEIVE.
REQ-016 IDLE -> HUNT on Enable=1; the history is cleared on entry to HUNT.
REQ-017 In HUNT, the block SHALL compare the post-shift windows W0 = shreg_next[15:8] and W1 = shreg_next[14:7] against SYNC_WORD.
REQ-018 On a match, the block SHALL store phase (0 for W0, 1 for W1), go to RECEIVE, and pulse Sync_found the following cycle. If both windows match, W1 wins.
REQ-019 In RECEIVE, a 2-bit pair counter SHALL start at 0 after sync; every 4th enabled cycle completes one byte.
REQ-020 A completed byte SHALL be taken from W0 or W1 according to the stored phase, registered to Byte_out, with Byte_valid=1 exactly one cycle after the input cycle that supplied its last bit.
REQ-021 After sync, no further sync-word matching SHALL occur until the next HUNT entry.
REQ-022 Enable=0 in any state SHALL force IDLE on the next edge: partial byte discarded, pair counter cleared, Active=0 on the next cycle, no Byte_valid for the partial byte.
REQ-023 Enable=1 with the FSM in IDLE on the same edge as a completed byte is impossible by construction; an Enable drop on the cycle a byte completes SHALL still deliver that byte.
REQ-024 Byte_out SHALL hold its last value when Byte_valid=0.

Reset
REQ-025 With RX_rst=1 at a rising edge, the block SHALL enter IDLE and clear shreg, the pair counter, phase and the hunt counter.
REQ-026 Reset SHALL take priority over Enable, including mid-byte and mid-hunt; all outputs are 0 in the cycle following reset, and no partial byte is emitted.

Configuration
REQ-027 Macro HS_RX_HUNT_TIMEOUT_EN SHALL select the hunt-timeout feature.
REQ-028 Macro defined: a hunt counter increments each HUNT cycle. On reaching HUNT_TIMEOUT without a match, the block pulses Sync_err for 1 cycle, re-enters HUNT with the history cleared, and restarts the counter.
REQ-029 Macro undefined: HUNT persists until sync or Enable=0, the hunt counter is not synthesized, and Sync_err is constant 0.

Verification
REQ-030 Phase-0 sync: pairs (B1,B2) = (0,0),(0,1),(1,1),(0,1) then byte 8'h5A -> Sync_found at cycle 5 after Enable, Active=1, Byte_out=8'h5A with Byte_valid at cycle 9.
REQ-031 Phase-1 sync: one leading 0 bit before 8'hB8 then bytes 8'h01, 8'hFF -> phase=1, Byte_out 8'h01 then 8'hFF on strobes exactly 4 cycles apart.
REQ-032 Enable drop 2 pairs into a byte after 8'h33 -> a single Byte_valid for 8'h33, none for the partial byte, Active=0 one cycle after the drop.
REQ-033 RX_rst pulse mid-RECEIVE -> all outputs 0 the next cycle; a re-sent sync plus 8'hC3 is recovered correctly.
REQ-034 With HS_RX_HUNT_TIMEOUT_EN defined and HUNT_TIMEOUT=64, 70 cycles of all-zero pairs -> Sync_err pulse at hunt cycle 64, no Sync_found; macro undefined -> Sync_err never asserts.

Source files
------------

// File: rtl/hs_rx_deserializer.sv
// HS lane receiver: hunts for the sync byte in a 2-bit/cycle DDR stream, then frames payload bytes.
// Optional hunt timeout with Sync_err pulse is built when HS_RX_HUNT_TIMEOUT_EN is defined.
module hs_rx_deserializer #(
    parameter logic [7:0] SYNC_WORD    = 8'hB8,
    parameter int         HUNT_TIMEOUT = 64
) (
    input  logic       RX_DDR_clk,
    input  logic       RX_rst,
    input  logic       Enable,
    input  logic       Serial_B1,
    input  logic       Serial_B2,
    output logic [7:0] Byte_out,
    output logic       Byte_valid,
    output logic       Sync_found,
    output logic       Active,
    output logic       Sync_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        RECEIVE = 2'd2
    } state_t;

    if (HUNT_TIMEOUT < 4 || HUNT_TIMEOUT > 1023) begin : g_bad_timeout
        $error("HUNT_TIMEOUT out of range 4..1023");
    end

    state_t      state, state_next;
    logic [15:0] shreg;
    logic [15:0] shreg_next;
    logic [1:0]  pair_cnt;
    logic        phase;
    logic        match_w0, match_w1, match;
    logic        byte_done;
    logic [7:0]  byte_sel;
    logic        hunt_expire;

    assign shreg_next = {Serial_B2, Serial_B1, shreg[15:2]};
    assign match_w0   = (shreg_next[15:8] == SYNC_WORD);
    assign match_w1   = (shreg_next[14:7] == SYNC_WORD);
    assign match      = (state == HUNT) && Enable && (match_w0 || match_w1);
    assign byte_done  = (state == RECEIVE) && Enable && (pair_cnt == 2'd3);
    assign byte_sel   = phase ? shreg_next[14:7] : shreg_next[15:8];

`ifdef HS_RX_HUNT_TIMEOUT_EN
    logic [9:0] hunt_cnt;

    assign hunt_expire = (state == HUNT) && Enable && !match &&
                         (hunt_cnt == 10'(HUNT_TIMEOUT - 1));

    // Counts enabled HUNT cycles; zero whenever a fresh hunt begins.
    always_ff @(posedge RX_DDR_clk) begin
        if (RX_rst) begin
            hunt_cnt <= '0;
        end else if (state != HUNT || !Enable || match || hunt_expire) begin
            hunt_cnt <= '0;
        end else begin
            hunt_cnt <= hunt_cnt + 10'd1;
        end
    end
`else
    assign hunt_expire = 1'b0;
`endif

    always_ff @(posedge RX_DDR_clk) begin
        if (RX_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!Enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = HUNT;
                HUNT:    state_next = match ? RECEIVE : HUNT;
                RECEIVE: state_next = RECEIVE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        Active = (state == RECEIVE);
    end

    // History clear on hunt (re)entry still captures the pair arriving that cycle.
    always_ff @(posedge RX_DDR_clk) begin
        if (RX_rst) begin
            shreg      <= '0;
            pair_cnt   <= '0;
            phase      <= 1'b0;
            Byte_out   <= '0;
            Byte_valid <= 1'b0;
            Sync_found <= 1'b0;
            Sync_err   <= 1'b0;
        end else begin
            Byte_valid <= byte_done;
            Sync_found <= match;
            Sync_err   <= hunt_expire;
            if (byte_done) begin
                Byte_out <= byte_sel;
            end
            if (!Enable) begin
                pair_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        shreg    <= {Serial_B2, Serial_B1, 14'b0};
                        pair_cnt <= '0;
                    end
                    HUNT: begin
                        shreg <= hunt_expire ? {Serial_B2, Serial_B1, 14'b0} : shreg_next;
                        if (match) begin
                            phase    <= match_w1;
                            pair_cnt <= '0;
                        end
                    end
                    RECEIVE: begin
                        shreg    <= shreg_next;
                        pair_cnt <= pair_cnt + 2'd1;
                    end
                    default: begin
                        pair_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hs_rx_deserializer.sv
// Bench for hs_rx_deserializer: directed table, corner-case sequences and a randomized run
// compared against a bit-queue reference model.
module tb_hs_rx_deserializer;

    localparam logic [7:0] SYNC    = 8'hB8;
    localparam int         TIMEOUT = 64;

    logic       clk;
    logic       RX_rst, Enable, Serial_B1, Serial_B2;
    logic [7:0] Byte_out;
    logic       Byte_valid, Sync_found, Active, Sync_err;

    hs_rx_deserializer #(.SYNC_WORD(SYNC), .HUNT_TIMEOUT(TIMEOUT)) dut (
        .RX_DDR_clk(clk),
        .RX_rst    (RX_rst),
        .Enable    (Enable),
        .Serial_B1 (Serial_B1),
        .Serial_B2 (Serial_B2),
        .Byte_out  (Byte_out),
        .Byte_valid(Byte_valid),
        .Sync_found(Sync_found),
        .Active    (Active),
        .Sync_err  (Sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: bits since hunt entry (preceded by 16 cleared bits) and payload bits after sync.
    int         m_mode;  // 0 idle, 1 hunting, 2 receiving
    bit         m_hist[$];
    bit         m_pay[$];
    int         m_pairs, m_hunt;
    logic [7:0] m_byte;
    bit         m_valid, m_sync, m_err;

    // Event records gathered by step()
    int         stepno;
    logic [7:0] rec_bytes[$];
    int         rec_bsteps[$];
    int         rec_ssteps[$];
    int         err_cnt;
    int         err_step;
    bit         tx_q[$];

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", name, got, exp, stepno);
        end
    endfunction

    function automatic logic [7:0] win(int last);
        logic [7:0] w;
        for (int i = 0; i < 8; i++) w[i] = m_hist[last - 7 + i];
        return w;
    endfunction

    function automatic void hist_restart(bit b1, bit b2);
        m_hist.delete();
        for (int i = 0; i < 16; i++) m_hist.push_back(1'b0);
        m_hist.push_back(b1);
        m_hist.push_back(b2);
        m_hunt = 0;
    endfunction

    function automatic void model_step(bit rst, bit en, bit b1, bit b2);
        int n;
        logic [7:0] w0, w1;
        m_valid = 0;
        m_sync  = 0;
        m_err   = 0;
        if (rst) begin
            m_mode = 0;
            m_byte = 8'h00;
            return;
        end
        if (!en) begin
            m_mode = 0;
            return;
        end
        case (m_mode)
            0: begin
                hist_restart(b1, b2);
                m_mode = 1;
            end
            1: begin
                m_hist.push_back(b1);
                m_hist.push_back(b2);
                m_hunt++;
                n  = m_hist.size();
                w0 = win(n - 1);
                w1 = win(n - 2);
                if (w1 == SYNC || w0 == SYNC) begin
                    m_pay.delete();
                    if (w1 == SYNC) m_pay.push_back(m_hist[n - 1]);
                    m_mode  = 2;
                    m_pairs = 0;
                    m_sync  = 1;
                end else begin
`ifdef HS_RX_HUNT_TIMEOUT_EN
                    if (m_hunt == TIMEOUT) begin
                        m_err = 1;
                        hist_restart(b1, b2);
                    end
`endif
                end
            end
            default: begin
                m_pay.push_back(b1);
                m_pay.push_back(b2);
                m_pairs++;
                if (m_pairs == 4) begin
                    m_pairs = 0;
                    for (int i = 0; i < 8; i++) m_byte[i] = m_pay.pop_front();
                    m_valid = 1;
                end
            end
        endcase
    endfunction

    task automatic step(input bit rst, input bit en, input bit b1, input bit b2);
        RX_rst    = rst;
        Enable    = en;
        Serial_B1 = b1;
        Serial_B2 = b2;
        model_step(rst, en, b1, b2);
        @(posedge clk);
        #1;
        stepno++;
        chk("model_valid",  Byte_valid, m_valid);
        chk("model_byte",   Byte_out,   m_byte);
        chk("model_sync",   Sync_found, m_sync);
        chk("model_active", Active,     m_mode == 2);
        chk("model_err",    Sync_err,   m_err);
        if (Byte_valid === 1'b1) begin
            rec_bytes.push_back(Byte_out);
            rec_bsteps.push_back(stepno);
        end
        if (Sync_found === 1'b1) rec_ssteps.push_back(stepno);
        if (Sync_err === 1'b1) begin
            err_cnt++;
            err_step = stepno;
        end
    endtask

    task automatic clear_rec();
        rec_bytes.delete();
        rec_bsteps.delete();
        rec_ssteps.delete();
        err_cnt  = 0;
        err_step = -1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) tx_q.push_back(b[i]);
    endtask

    task automatic flush();
        bit b1, b2;
        while (tx_q.size() > 0) begin
            b1 = tx_q.pop_front();
            b2 = (tx_q.size() > 0) ? tx_q.pop_front() : 1'b0;
            step(1'b0, 1'b1, b1, b2);
        end
    endtask

    function automatic logic [7:0] rb(int i);
        return (i < rec_bytes.size()) ? rec_bytes[i] : 8'hxx;
    endfunction

    function automatic int rbs(int i);
        return (i < rec_bsteps.size()) ? rec_bsteps[i] : -1;
    endfunction

    function automatic int rss(int i);
        return (i < rec_ssteps.size()) ? rec_ssteps[i] : -1;
    endfunction

    typedef struct {
        bit         rst, en, b1, b2;
        bit         valid;
        logic [7:0] bout;
        bit         sync, active;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit b1, b2, en, rst;
        RX_rst = 1'b1; Enable = 1'b0; Serial_B1 = 1'b0; Serial_B2 = 1'b0;
        stepno = 0; m_mode = 0; m_byte = 8'h00; m_pairs = 0; m_hunt = 0;
        clear_rec();

        // Phase-0 sync (B8 as pairs) followed by 8'h5A, then Enable drop
        tbl[0]  = '{1, 0, 0, 0, 0, 8'h00, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 8'h00, 0, 0};
        tbl[2]  = '{0, 1, 0, 1, 0, 8'h00, 0, 0};
        tbl[3]  = '{0, 1, 1, 1, 0, 8'h00, 0, 0};
        tbl[4]  = '{0, 1, 0, 1, 0, 8'h00, 1, 1};
        tbl[5]  = '{0, 1, 0, 1, 0, 8'h00, 0, 1};
        tbl[6]  = '{0, 1, 0, 1, 0, 8'h00, 0, 1};
        tbl[7]  = '{0, 1, 1, 0, 0, 8'h00, 0, 1};
        tbl[8]  = '{0, 1, 1, 0, 1, 8'h5A, 0, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 8'h5A, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 8'h5A, 0, 0};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].b1, tbl[i].b2);
            chk($sformatf("tbl%0d_valid", i),  Byte_valid, tbl[i].valid);
            chk($sformatf("tbl%0d_byte", i),   Byte_out,   tbl[i].bout);
            chk($sformatf("tbl%0d_sync", i),   Sync_found, tbl[i].sync);
            chk($sformatf("tbl%0d_active", i), Active,     tbl[i].active);
            chk($sformatf("tbl%0d_err", i),    Sync_err,   1'b0);
        end

        // Phase-1 sync: one leading 0 bit, then B8, 01, FF
        step(1'b1, 1'b0, 1'b0, 1'b0);
        clear_rec();
        base = stepno;
        tx_q.push_back(1'b0);
        push_byte(SYNC);
        push_byte(8'h01);
        push_byte(8'hFF);
        flush();
        chk("p1_sync_step", rss(0), base + 5);
        chk("p1_nbytes", rec_bytes.size(), 2);
        chk("p1_byte0", rb(0), 8'h01);
        chk("p1_byte1", rb(1), 8'hFF);
        chk("p1_step0", rbs(0), base + 9);
        chk("p1_gap", rbs(1) - rbs(0), 4);

        // Enable drop two pairs into the byte after 8'h33
        step(1'b1, 1'b0, 1'b0, 1'b0);
        clear_rec();
        push_byte(SYNC);
        push_byte(8'h33);
        tx_q.push_back(1'b1); tx_q.push_back(1'b0);
        tx_q.push_back(1'b1); tx_q.push_back(1'b1);
        flush();
        chk("drop_active_before", Active, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("drop_active_after", Active, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("drop_nbytes", rec_bytes.size(), 1);
        chk("drop_byte", rb(0), 8'h33);

        // Reset mid-RECEIVE, then resync and recover 8'hC3
        step(1'b1, 1'b0, 1'b0, 1'b0);
        push_byte(SYNC);
        push_byte(8'h5A);
        tx_q.push_back(1'b1); tx_q.push_back(1'b1);
        tx_q.push_back(1'b0); tx_q.push_back(1'b1);
        flush();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_byte",   Byte_out,   8'h00);
        chk("rst_valid",  Byte_valid, 1'b0);
        chk("rst_sync",   Sync_found, 1'b0);
        chk("rst_active", Active,     1'b0);
        chk("rst_err",    Sync_err,   1'b0);
        clear_rec();
        push_byte(SYNC);
        push_byte(8'hC3);
        flush();
        chk("rst_resync_nbytes", rec_bytes.size(), 1);
        chk("rst_resync_byte", rb(0), 8'hC3);

        // 70 cycles of all-zero pairs while hunting
        step(1'b1, 1'b0, 1'b0, 1'b0);
        clear_rec();
        base = stepno;
        for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("hunt_nsync", rec_ssteps.size(), 0);
`ifdef HS_RX_HUNT_TIMEOUT_EN
        chk("hunt_nerr", err_cnt, 1);
        chk("hunt_err_step", err_step, base + TIMEOUT + 1);
`else
        chk("hunt_nerr", err_cnt, 0);
`endif

        // Randomized traffic with injected sync words, Enable drops and resets
        step(1'b1, 1'b0, 1'b0, 1'b0);
        tx_q.delete();
        for (int i = 0; i < 4000; i++) begin
            if (tx_q.size() < 2) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 1) tx_q.push_back(1'($urandom_range(0, 1)));
                    push_byte(SYNC);
                end else begin
                    push_byte(8'($urandom_range(0, 255)));
                end
            end
            b1  = tx_q.pop_front();
            b2  = tx_q.pop_front();
            en  = ($urandom_range(0, 49) != 0);
            rst = ($urandom_range(0, 399) == 0);
            step(rst, en, b1, b2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
